// File: rtl/mac_feeder.sv
// Initiator for the registered 4-lane MAC wrapper: streams operand groups in,
// feeds each partial sum back as the next group's c, and returns the final sum.
module mac_feeder #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int cnt_bw  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [cnt_bw-1:0]    num_groups,
  input  logic [psum_bw-1:0]   bias,
  output logic                 busy,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*bw-1:0]      in_a,
  input  logic [4*bw-1:0]      in_b,
  output logic [bw-1:0]        mac_a0,
  output logic [bw-1:0]        mac_a1,
  output logic [bw-1:0]        mac_a2,
  output logic [bw-1:0]        mac_a3,
  output logic [bw-1:0]        mac_b0,
  output logic [bw-1:0]        mac_b1,
  output logic [bw-1:0]        mac_b2,
  output logic [bw-1:0]        mac_b3,
  output logic [psum_bw-1:0]   mac_c,
  input  logic [psum_bw-1:0]   mac_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [psum_bw-1:0]   out_data
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [cnt_bw-1:0] CNT_ZERO = {cnt_bw{1'b0}};
  localparam logic [cnt_bw-1:0] CNT_ONE  = {{(cnt_bw-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [psum_bw-1:0]   acc_q, acc_d;
  logic [cnt_bw-1:0]    remaining_q, remaining_d;

  // State register, accumulator and group counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= {psum_bw{1'b0}};
      remaining_q <= CNT_ZERO;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      remaining_q <= remaining_d;
    end
  end

  // Next-state logic and handshake/MAC drive; lanes are zero unless a group is accepted.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    remaining_d = remaining_q;
    busy        = 1'b1;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_data    = acc_q;
    mac_c       = acc_q;
    mac_a0      = {bw{1'b0}};
    mac_a1      = {bw{1'b0}};
    mac_a2      = {bw{1'b0}};
    mac_a3      = {bw{1'b0}};
    mac_b0      = {bw{1'b0}};
    mac_b1      = {bw{1'b0}};
    mac_b2      = {bw{1'b0}};
    mac_b3      = {bw{1'b0}};
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          acc_d       = bias;
          remaining_d = num_groups;
          state_d     = (num_groups == CNT_ZERO) ? DONE : ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mac_a0  = in_a[0*bw +: bw];
          mac_a1  = in_a[1*bw +: bw];
          mac_a2  = in_a[2*bw +: bw];
          mac_a3  = in_a[3*bw +: bw];
          mac_b0  = in_b[0*bw +: bw];
          mac_b1  = in_b[1*bw +: bw];
          mac_b2  = in_b[2*bw +: bw];
          mac_b3  = in_b[3*bw +: bw];
          state_d = CAPTURE;
        end else begin
          state_d = ISSUE;
        end
      end
      CAPTURE: begin
        // The wrapper's output now reflects the group issued last cycle.
        acc_d       = mac_out;
        remaining_d = remaining_q - CNT_ONE;
        state_d     = (remaining_q == CNT_ONE) ? DONE : ISSUE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mac_feeder.sv
// Randomized self-checking bench for mac_feeder with a behavioural MAC wrapper
// and a dot-product reference model.
module tb_mac_feeder;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, out_ready;
  logic [7:0]  num_groups;
  logic [15:0] bias, in_a, in_b, mac_c, mac_out, out_data;
  logic [3:0]  mac_a0, mac_a1, mac_a2, mac_a3, mac_b0, mac_b1, mac_b2, mac_b3;
  logic        busy, in_ready, out_valid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mac_feeder #(.bw(4), .psum_bw(16), .cnt_bw(8)) dut (
    .clk(clk), .reset(reset), .start(start), .num_groups(num_groups), .bias(bias),
    .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_a0(mac_a0), .mac_a1(mac_a1), .mac_a2(mac_a2), .mac_a3(mac_a3),
    .mac_b0(mac_b0), .mac_b1(mac_b1), .mac_b2(mac_b2), .mac_b3(mac_b3),
    .mac_c(mac_c), .mac_out(mac_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data)
  );

  // Behavioural MAC wrapper: inputs registered, sum of products plus c one cycle later.
  logic [3:0]  ra [4];
  logic [3:0]  rb [4];
  logic [15:0] rc;
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) begin ra[k] <= 4'd0; rb[k] <= 4'd0; end
      rc <= 16'd0;
    end else begin
      ra[0] <= mac_a0; ra[1] <= mac_a1; ra[2] <= mac_a2; ra[3] <= mac_a3;
      rb[0] <= mac_b0; rb[1] <= mac_b1; rb[2] <= mac_b2; rb[3] <= mac_b3;
      rc <= mac_c;
    end
  end
  assign mac_out = 16'(int'(ra[0]) * int'(rb[0]) + int'(ra[1]) * int'(rb[1]) +
                       int'(ra[2]) * int'(rb[2]) + int'(ra[3]) * int'(rb[3]) + int'(rc));

  function automatic logic [15:0] dot(input logic [15:0] a, input logic [15:0] b);
    int s = 0;
    for (int k = 0; k < 4; k++) s += int'(a[4*k +: 4]) * int'(b[4*k +: 4]);
    return 16'(s);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: random operands, 1: a={1,2,3,4} b=1s, 2: a={4,4,4,4} b=1s
  task automatic run_job(input int n, input logic [15:0] b, input int mode,
                         input int stall, input int hold);
    logic [15:0] ga[$];
    logic [15:0] gb[$];
    logic [15:0] exp_sum, part;
    int c, gi, st, st_left;
    for (int i = 0; i < n; i++) begin
      case (mode)
        1:       begin ga.push_back(16'h4321); gb.push_back(16'h1111); end
        2:       begin ga.push_back(16'h4444); gb.push_back(16'h1111); end
        default: begin ga.push_back(16'($urandom)); gb.push_back(16'($urandom)); end
      endcase
    end
    exp_sum = b;
    for (int i = 0; i < n; i++) exp_sum = exp_sum + dot(ga[i], gb[i]);
    st = (n > 1) ? stall : 0;
    st_left = st;

    start = 1'b1; num_groups = 8'(n); bias = b; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("idle_status", 32'({busy, in_ready, out_valid}), 32'd0);
    tick();
    start = 1'b0;
    c = 1; gi = 0; part = b;
    while (1) begin
      if (in_ready && gi == 1 && st_left > 0) begin
        in_valid = 1'b0;
        st_left--;
      end else if (gi < n) begin
        in_valid = 1'b1; in_a = ga[gi]; in_b = gb[gi];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid) break;
      if (c >= 2*n + st + 20) begin
        chk("timeout_out_valid", 32'(out_valid), 32'd1);
        break;
      end
      chk("busy", 32'(busy), 32'd1);
      if (in_ready) chk("mac_c_issue", 32'(mac_c), 32'(part));
      if (in_ready && in_valid) begin
        chk("mac_a_lanes", 32'({mac_a3, mac_a2, mac_a1, mac_a0}), 32'(ga[gi]));
        chk("mac_b_lanes", 32'({mac_b3, mac_b2, mac_b1, mac_b0}), 32'(gb[gi]));
        if (st == 0) chk("hs_cycle", 32'(c), 32'(2*gi + 1));
        part = part + dot(ga[gi], gb[gi]);
        gi++;
      end else begin
        chk("mac_ab_zero", 32'({mac_a3, mac_a2, mac_a1, mac_a0, mac_b3, mac_b2, mac_b1, mac_b0}), 32'd0);
      end
      tick();
      c++;
    end
    in_valid = 1'b0;
    chk("done_cycle", 32'(c), 32'(2*n + 1 + st));
    chk("groups_accepted", 32'(gi), 32'(n));
    chk("result", 32'(out_data), 32'(exp_sum));
    chk("done_ab_zero", 32'({mac_a3, mac_a2, mac_a1, mac_a0, mac_b3, mac_b2, mac_b1, mac_b0}), 32'd0);

    for (int h = 0; h < hold; h++) begin
      tick();
      start = ~start; num_groups = 8'($urandom); bias = 16'($urandom);
      #1;
      chk("hold_valid", 32'({out_valid, busy, in_ready}), 32'b110);
      chk("hold_data", 32'(out_data), 32'(exp_sum));
    end
    tick();
    out_ready = 1'b1; start = 1'b1; num_groups = 8'd5;
    #1;
    chk("hs_valid", 32'(out_valid), 32'd1);
    tick();
    out_ready = 1'b0; start = 1'b0;
    #1;
    chk("idle_after_done", 32'({busy, out_valid, in_ready}), 32'd0);
  endtask

  task automatic run_abort();
    int gi = 0;
    start = 1'b1; num_groups = 8'd3; bias = 16'($urandom); in_valid = 1'b0; out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 20 && gi < 2; c++) begin
      in_valid = 1'b1; in_a = 16'($urandom); in_b = 16'($urandom);
      #1;
      if (in_ready && in_valid) gi++;
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("abort_in_capture", 32'({busy, in_ready}), 32'b10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("abort_idle", 32'({busy, out_valid, in_ready}), 32'd0);
    chk("abort_acc", 32'(mac_c), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk("abort_no_result", 32'({busy, out_valid}), 32'd0);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; num_groups = 8'd0; bias = 16'd0;
    in_valid = 1'b0; in_a = 16'd0; in_b = 16'd0; out_ready = 1'b0;
    tick(); tick();
    #1;
    chk("reset_status", 32'({busy, in_ready, out_valid}), 32'd0);
    chk("reset_data", 32'({out_data, mac_c}), 32'd0);
    tick();
    reset = 1'b0;

    run_job(3, 16'd5, 1, 0, 0);
    run_job(0, 16'h1234, 0, 0, 0);
    run_job(3, 16'd5, 1, 4, 0);
    run_job(3, 16'd5, 1, 0, 5);
    run_job(2, 16'($urandom), 0, 0, 0);
    run_abort();
    run_job(3, 16'd5, 1, 0, 0);
    run_job(2, 16'hFFF0, 2, 0, 0);
    for (int j = 0; j < 8; j++)
      run_job(int'($urandom_range(1, 12)), 16'($urandom), 0,
              int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
    run_job(255, 16'($urandom), 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
